// File: rtl/regfile_pkg.sv
// Shared defaults and operand types for the register file and its consumers in decode/datapath.
package regfile_pkg;

  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefNrd   = 2;
  localparam int unsigned DefAw    = $clog2(DefDepth);

  typedef logic [DefAw-1:0] reg_addr_t;
  typedef logic [DefDw-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus a registered count of busy registers.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             SetEn,
  input  logic [AW-1:0]    SetAddr,
  input  logic             Wen,
  input  logic [AW-1:0]    Wd,
  output logic [DEPTH-1:0] Busy,
  output logic [CW-1:0]    PendCnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_ok, set_ok;

  assign wr_ok  = Wen   && !(ZERO_R0 && (Wd == '0));
  assign set_ok = SetEn && !(ZERO_R0 && (SetAddr == '0));

  // Set is applied after the clear so a new producer wins over the resolving write.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[Wd] = 1'b0;
    end
    if (set_ok) begin
      busy_d[SetAddr] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Busy    = busy_q;
  assign PendCnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with optional write-through bypass, hard-wired r0 and an
// integrated write-pending scoreboard for RAW hazard stalls.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned NRD     = DefNrd,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Wen,
  input  logic [AW-1:0]           Wd,
  input  logic [DW-1:0]           Wdat,
  input  logic                    SetEn,
  input  logic [AW-1:0]           SetAddr,
  input  logic [NRD-1:0][AW-1:0]  Ra,
  output logic [NRD-1:0][DW-1:0]  Rdat,
  output logic [NRD-1:0]          RBusy,
  output logic [CW-1:0]           PendCnt
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_ok;

  assign wr_ok = Wen && !(ZERO_R0 && (Wd == '0));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[Wd] <= Wdat;
    end
  end

  reg_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .SetEn   (SetEn),
    .SetAddr (SetAddr),
    .Wen     (Wen),
    .Wd      (Wd),
    .Busy    (busy),
    .PendCnt (PendCnt)
  );

  // Forwarded data is the resolving write, so a bypassed port never reports busy.
  // Outputs are forced low while in reset so a pending write cannot leak through the bypass.
  always_comb begin
    Rdat  = '0;
    RBusy = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      Rdat[p]  = mem_q[Ra[p]];
      RBusy[p] = busy[Ra[p]];
      if (BYPASS && wr_ok && (Wd == Ra[p])) begin
        Rdat[p]  = Wdat;
        RBusy[p] = 1'b0;
      end
      if (!Reset_n || (ZERO_R0 && (Ra[p] == '0))) begin
        Rdat[p]  = '0;
        RBusy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven by one stimulus stream and checked
// against an array-based reference model.
module tb_regfile_sb;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wen, set_en;
  logic [3:0]      wd, set_addr;
  logic [7:0]      wdat;
  logic [3:0][3:0] ra;

  logic [1:0][7:0] rdat_a, rdat_b;
  logic [1:0]      rbusy_a, rbusy_b;
  logic [3:0]      pcnt_a, pcnt_b;
  logic [3:0][7:0] rdat_c;
  logic [3:0]      rbusy_c;
  logic [4:0]      pcnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cfg0 = bypass, cfg1 = no bypass + zero r0, cfg2 = 16 deep, 4 ports.
  logic [7:0] mm [3][16];
  bit         mb [3][16];
  int         dep [3] = '{8, 8, 16};
  bit         byp [3] = '{1'b1, 1'b0, 1'b1};
  bit         zr  [3] = '{1'b0, 1'b1, 1'b0};
  int         np  [3] = '{2, 2, 4};

  always #5 clk = ~clk;

  regfile_sb #(.DW(8), .DEPTH(8), .NRD(2), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .Wen(wen), .Wd(wd[2:0]), .Wdat(wdat), .SetEn(set_en),
    .SetAddr(set_addr[2:0]), .Ra({ra[1][2:0], ra[0][2:0]}), .Rdat(rdat_a), .RBusy(rbusy_a),
    .PendCnt(pcnt_a)
  );

  regfile_sb #(.DW(8), .DEPTH(8), .NRD(2), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Wen(wen), .Wd(wd[2:0]), .Wdat(wdat), .SetEn(set_en),
    .SetAddr(set_addr[2:0]), .Ra({ra[1][2:0], ra[0][2:0]}), .Rdat(rdat_b), .RBusy(rbusy_b),
    .PendCnt(pcnt_b)
  );

  regfile_sb #(.DW(8), .DEPTH(16), .NRD(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .Wen(wen), .Wd(wd), .Wdat(wdat), .SetEn(set_en),
    .SetAddr(set_addr), .Ra(ra), .Rdat(rdat_c), .RBusy(rbusy_c), .PendCnt(pcnt_c)
  );

  function automatic logic [7:0] got_rd(int k, int p);
    case (k)
      0:       return rdat_a[1'(p)];
      1:       return rdat_b[1'(p)];
      default: return rdat_c[2'(p)];
    endcase
  endfunction

  function automatic logic got_rb(int k, int p);
    case (k)
      0:       return rbusy_a[1'(p)];
      1:       return rbusy_b[1'(p)];
      default: return rbusy_c[2'(p)];
    endcase
  endfunction

  function automatic int got_cnt(int k);
    case (k)
      0:       return int'(pcnt_a);
      1:       return int'(pcnt_b);
      default: return int'(pcnt_c);
    endcase
  endfunction

  function automatic logic [7:0] exp_rd(int k, int p);
    int a = int'(ra[p]) % dep[k];
    if (!rst_n) return 8'h00;
    if (zr[k] && a == 0) return 8'h00;
    if (byp[k] && wen && (int'(wd) % dep[k]) == a) return wdat;
    return mm[k][a];
  endfunction

  function automatic logic exp_rb(int k, int p);
    int a = int'(ra[p]) % dep[k];
    if (!rst_n) return 1'b0;
    if (zr[k] && a == 0) return 1'b0;
    if (byp[k] && wen && (int'(wd) % dep[k]) == a) return 1'b0;
    return mb[k][a];
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    for (int a = 0; a < dep[k]; a++) c += int'(mb[k][a]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) begin
        mm[k][a] = 8'h00;
        mb[k][a] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int w, s;
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      w = int'(wd) % dep[k];
      s = int'(set_addr) % dep[k];
      if (wen && !(zr[k] && w == 0)) begin
        mm[k][w] = wdat;
        mb[k][w] = 1'b0;
      end
      if (set_en && !(zr[k] && s == 0)) mb[k][s] = 1'b1;
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; set_en = 1'b0; wd = '0; set_addr = '0; wdat = '0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_cnt(k) !== 0) begin
        n_fail++; $display("FAIL reset_cnt cfg%0d: got %0d expected 0", k, got_cnt(k));
      end
      for (int p = 0; p < np[k]; p++) begin
        n_tests++;
        if (got_rd(k, p) !== 8'h00 || got_rb(k, p) !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read cfg%0d p%0d: got %h/%b expected 00/0", k, p,
                   got_rd(k, p), got_rb(k, p));
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    wen = 1'b1; wd = 4'd3; wdat = 8'hA5; set_en = 1'b1; set_addr = 4'd2;
    tick();
    idle(); ra[0] = 4'd3;
    #2;
    n_tests++;
    if (got_rd(0, 0) !== 8'hA5 || got_cnt(0) !== 1) begin
      n_fail++; $display("FAIL mid_pre: got %h cnt %0d expected a5 cnt 1", got_rd(0, 0), got_cnt(0));
    end
    rst_n = 1'b0; model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rd(k, 0) !== 8'h00 || got_cnt(k) !== 0) begin
        n_fail++;
        $display("FAIL mid_reset cfg%0d: got %h cnt %0d expected 00 cnt 0", k, got_rd(k, 0), got_cnt(k));
      end
    end
    wen = 1'b1; wd = 4'd3; wdat = 8'h5A;
    #1;
    n_tests++;
    if (got_rd(0, 0) !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_bypass: got %h expected 00", got_rd(0, 0));
    end
    tick();
    idle();
    #2 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rd(k, 0) !== 8'h00) begin
        n_fail++; $display("FAIL mid_release cfg%0d: got %h expected 00", k, got_rd(k, 0));
      end
    end
    tick();
  endtask

  task automatic test_bypass();
    idle(); wen = 1'b1; wd = 4'd5; wdat = 8'h10;
    tick();
    wdat = 8'h3C; ra[0] = 4'd5;
    #2;
    n_tests++;
    if (got_rd(0, 0) !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_on: got %h expected 3c", got_rd(0, 0));
    end
    n_tests++;
    if (got_rd(1, 0) !== 8'h10) begin
      n_fail++; $display("FAIL bypass_off_old: got %h expected 10", got_rd(1, 0));
    end
    n_tests++;
    if (got_rd(2, 0) !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_on_c: got %h expected 3c", got_rd(2, 0));
    end
    tick();
    idle();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rd(k, 0) !== 8'h3C) begin
        n_fail++; $display("FAIL bypass_after cfg%0d: got %h expected 3c", k, got_rd(k, 0));
      end
    end
  endtask

  task automatic test_scoreboard();
    idle(); set_en = 1'b1; set_addr = 4'd2; ra[1] = 4'd2;
    tick();
    idle();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rb(k, 1) !== 1'b1 || got_cnt(k) !== 1) begin
        n_fail++;
        $display("FAIL sb_set cfg%0d: got busy %b cnt %0d expected 1 cnt 1", k, got_rb(k, 1), got_cnt(k));
      end
    end
    wen = 1'b1; wd = 4'd2; wdat = 8'h11;
    #2;
    n_tests++;
    if (got_rb(0, 1) !== 1'b0 || got_rd(0, 1) !== 8'h11) begin
      n_fail++; $display("FAIL sb_fwd: got %b/%h expected 0/11", got_rb(0, 1), got_rd(0, 1));
    end
    n_tests++;
    if (got_rb(1, 1) !== 1'b1) begin
      n_fail++; $display("FAIL sb_nofwd: got busy %b expected 1", got_rb(1, 1));
    end
    tick();
    idle();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rb(k, 1) !== 1'b0 || got_cnt(k) !== 0 || got_rd(k, 1) !== 8'h11) begin
        n_fail++;
        $display("FAIL sb_clear cfg%0d: got %b cnt %0d %h expected 0 cnt 0 11", k, got_rb(k, 1),
                 got_cnt(k), got_rd(k, 1));
      end
    end
  endtask

  task automatic test_collision();
    idle(); set_en = 1'b1; set_addr = 4'd4;
    tick();
    set_addr = 4'd6;
    tick();
    wen = 1'b1; wd = 4'd4; wdat = 8'h77; set_addr = 4'd4; ra[0] = 4'd4;
    tick();
    idle();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_rd(k, 0) !== 8'h77 || got_rb(k, 0) !== 1'b1 || got_cnt(k) !== 2) begin
        n_fail++;
        $display("FAIL coll_same cfg%0d: got %h/%b cnt %0d expected 77/1 cnt 2", k, got_rd(k, 0),
                 got_rb(k, 0), got_cnt(k));
      end
    end
    set_en = 1'b1; set_addr = 4'd1; wen = 1'b1; wd = 4'd6; wdat = 8'h66;
    tick();
    idle(); ra[0] = 4'd1; ra[1] = 4'd6;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got_cnt(k) !== 2 || got_rb(k, 0) !== 1'b1 || got_rb(k, 1) !== 1'b0 ||
          got_rd(k, 1) !== 8'h66) begin
        n_fail++;
        $display("FAIL coll_net cfg%0d: got cnt %0d busy %b%b %h expected cnt 2 busy 10 66", k,
                 got_cnt(k), got_rb(k, 0), got_rb(k, 1), got_rd(k, 1));
      end
    end
  endtask

  task automatic test_zero();
    idle(); wen = 1'b1; wd = 4'd0; wdat = 8'hFF; set_en = 1'b1; set_addr = 4'd0;
    ra[0] = 4'd0; ra[1] = 4'd0;
    #2;
    n_tests++;
    if (got_rd(1, 0) !== 8'h00 || got_rb(1, 0) !== 1'b0) begin
      n_fail++; $display("FAIL zero_same: got %h/%b expected 00/0", got_rd(1, 0), got_rb(1, 0));
    end
    tick();
    idle();
    #2;
    n_tests++;
    if (got_rd(1, 1) !== 8'h00 || got_rb(1, 1) !== 1'b0 || got_cnt(1) !== 2) begin
      n_fail++;
      $display("FAIL zero_after: got %h/%b cnt %0d expected 00/0 cnt 2", got_rd(1, 1), got_rb(1, 1),
               got_cnt(1));
    end
    n_tests++;
    if (got_rd(0, 0) !== 8'hFF || got_rb(0, 0) !== 1'b1 || got_cnt(0) !== 3) begin
      n_fail++;
      $display("FAIL zero_normal_r0: got %h/%b cnt %0d expected ff/1 cnt 3", got_rd(0, 0),
               got_rb(0, 0), got_cnt(0));
    end
  endtask

  task automatic test_full();
    idle();
    for (int a = 0; a < 16; a++) begin
      set_en = 1'b1; set_addr = 4'(a);
      tick();
    end
    idle();
    for (int p = 0; p < 4; p++) ra[p] = 4'd9;
    #2;
    n_tests++;
    if (got_cnt(2) !== 16) begin
      n_fail++; $display("FAIL full_cnt16: got %0d expected 16", got_cnt(2));
    end
    n_tests++;
    if (got_cnt(0) !== 8 || got_cnt(1) !== 7) begin
      n_fail++; $display("FAIL full_cnt8: got %0d/%0d expected 8/7", got_cnt(0), got_cnt(1));
    end
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (got_rb(2, p) !== 1'b1 || got_rd(2, p) !== got_rd(2, 0) || got_rd(2, p) !== 8'h00) begin
        n_fail++;
        $display("FAIL full_port p%0d: got %h/%b expected 00/1", p, got_rd(2, p), got_rb(2, p));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wen      = 1'($urandom_range(0, 1));
      set_en   = 1'($urandom_range(0, 1));
      wd       = 4'($urandom_range(0, 15));
      set_addr = 4'($urandom_range(0, 15));
      wdat     = 8'($urandom);
      for (int p = 0; p < 4; p++) ra[p] = 4'($urandom_range(0, 15));
      if (n % 5 == 0) ra[1] = wd;
      #2;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got_cnt(k) !== exp_cnt(k)) begin
          n_fail++;
          $display("FAIL rand_cnt n%0d cfg%0d: got %0d expected %0d", n, k, got_cnt(k), exp_cnt(k));
        end
        for (int p = 0; p < np[k]; p++) begin
          n_tests++;
          if (got_rd(k, p) !== exp_rd(k, p) || got_rb(k, p) !== exp_rb(k, p)) begin
            n_fail++;
            $display("FAIL rand_read n%0d cfg%0d p%0d: got %h/%b expected %h/%b", n, k, p,
                     got_rd(k, p), got_rb(k, p), exp_rd(k, p), exp_rb(k, p));
          end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    ra = '0;
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_reset_mid();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_zero();
    test_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
